// File: rtl/alarm_pkg.sv
// alarm_pkg: state encoding and counter widths shared by the alarm snooze sequencer.
package alarm_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2,
    LOCKOUT = 2'd3
  } state_t;
  localparam int TMR_W = 6;
  localparam int SNZ_W = 3;
endpackage

// File: rtl/minute_timer.sv
// minute_timer: loadable down counter stepped by the minute tick; flags the 1->0 step.
module minute_timer
  import alarm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             tick,
  output logic             expire
);
  logic [TMR_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (tick && cnt_q != '0) ? cnt_q - TMR_W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign expire = tick && cnt_q == TMR_W'(1);
endmodule

// File: rtl/alarm_snooze_ctrl.sv
// alarm_snooze_ctrl: ring/snooze/stop/timeout sequencer between alarm comparator and speaker.
// Define ALARM_BEEP_EN to chop RING into a beep of BEEP_HALF_CYCLES-cycle half periods.
module alarm_snooze_ctrl
  import alarm_pkg::*;
#(
`ifdef ALARM_BEEP_EN
  parameter int BEEP_HALF_CYCLES  = 4,
`endif
  parameter int SNOOZE_MINS       = 9,
  parameter int RING_TIMEOUT_MINS = 10,
  parameter int MAX_SNOOZES       = 3
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       MIN_TICK,
  input  logic       COMPARE_IN,
  input  logic       TOGGLE_ON,
  input  logic       SNOOZE_REQ,
  input  logic       STOP_REQ,
  output logic       RING,
  output logic       SNOOZING,
  output logic [2:0] SNOOZE_CNT,
  output logic       SESSION_END
);
  state_t           state_q, state_d;
  logic             cmp_prev_q;
  logic             ring_q, ring_d, snoozing_q, snoozing_d, end_q, end_d;
  logic [SNZ_W-1:0] snz_q, snz_d;
  logic             ld, tick, expire, halt;
  logic [TMR_W-1:0] ld_val;
  assign tick = MIN_TICK && (state_q == RINGING || state_q == SNOOZE);
  assign halt = !TOGGLE_ON || STOP_REQ;
  minute_timer u_timer (
    .clk     (CLK),
    .rst_n   (RESETN),
    .load    (ld),
    .load_val(ld_val),
    .tick    (tick),
    .expire  (expire)
  );
  always_comb begin
    state_d = state_q;
    snz_d   = snz_q;
    end_d   = 1'b0;
    ld      = 1'b0;
    ld_val  = TMR_W'(RING_TIMEOUT_MINS);
    case (state_q)
      IDLE: if (TOGGLE_ON && COMPARE_IN && !cmp_prev_q) begin
        state_d = RINGING;
        ld      = 1'b1;
      end
      RINGING: if (halt) begin
        state_d = LOCKOUT;
        end_d   = 1'b1;
      end else if (SNOOZE_REQ && snz_q < SNZ_W'(MAX_SNOOZES)) begin
        state_d = SNOOZE;
        snz_d   = snz_q + SNZ_W'(1);
        ld      = 1'b1;
        ld_val  = TMR_W'(SNOOZE_MINS);
      end else if (expire) begin
        state_d = LOCKOUT;
        end_d   = 1'b1;
      end
      SNOOZE: if (halt) begin
        state_d = LOCKOUT;
        end_d   = 1'b1;
      end else if (expire) begin
        state_d = RINGING;
        ld      = 1'b1;
      end
      LOCKOUT: if (!COMPARE_IN) begin
        state_d = IDLE;
        snz_d   = '0;
      end
    endcase
  end
  assign snoozing_d = state_d == SNOOZE;
`ifdef ALARM_BEEP_EN
  logic [7:0] ph_q, ph_d;
  logic       beep_q, beep_d, entry, wrap;
  always_comb begin
    entry  = state_d == RINGING && state_q != RINGING;
    wrap   = ph_q == 8'(BEEP_HALF_CYCLES - 1);
    ph_d   = (entry || wrap) ? 8'd0 : ph_q + 8'd1;
    beep_d = entry ? 1'b1 : wrap ? !beep_q : beep_q;
  end
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ph_q   <= '0;
      beep_q <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      beep_q <= beep_d;
    end
  end
  assign ring_d = state_d == RINGING && beep_d;
`else
  assign ring_d = state_d == RINGING;
`endif
  // cmp_prev resets high so a match already in progress at reset release is not an edge
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= IDLE;
      cmp_prev_q <= 1'b1;
      snz_q      <= '0;
      ring_q     <= 1'b0;
      snoozing_q <= 1'b0;
      end_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmp_prev_q <= COMPARE_IN;
      snz_q      <= snz_d;
      ring_q     <= ring_d;
      snoozing_q <= snoozing_d;
      end_q      <= end_d;
    end
  end
  assign RING        = ring_q;
  assign SNOOZING    = snoozing_q;
  assign SNOOZE_CNT  = snz_q;
  assign SESSION_END = end_q;
endmodule
